vga_scan_reader: RTL and testbench
==================================

// Module: vga_scan_reader
// PURPOSE
//  Read side of the frame buffer: generates 640x480@60 VGA timing and scans the
//  1-bit pixel store in raster order. Drives readX/readY combinationally into the
//  store, samples the returned color bit and emits aligned RGB + sync to the DAC.
//  Also exports frame/vblank status so the Pi-simulator writer can time updates.
// PARAMETERS
//  H_VISIBLE 640 | H_FRONT 16 | H_SYNC 96 | H_BACK 48  -- pixels; H_TOTAL = sum = 800
//  V_VISIBLE 480 | V_FRONT 10 | V_SYNC 2  | V_BACK 33  -- lines;  V_TOTAL = sum = 525
//  CLK_DIV   2        clk cycles per pixel tick (1 => tick every clk)
//  FG_COLOR  12'hFFF  RGB444 for color==1; BG_COLOR 12'h000 for color==0
// PORTS
//  clk        in   1   system clock; only clock
//  reset_n    in   1   asynchronous, active-low reset
//  readX      out  10  pixel-store read column, combinational from hCount
//  readY      out  10  pixel-store read row, combinational from vCount
//  color      in   1   pixel-store read data, combinational response to readX/readY
//  vga_r/g/b  out  4 each  registered RGB444
//  hsync      out  1   registered, active-low
//  vsync      out  1   registered, active-low
//  pxTick     out  1   1-clk pixel-advance strobe
//  inVblank   out  1   registered level, 1 while vCount >= V_VISIBLE
//  frameStart out  1   1-clk pulse on tick where counters wrap to (0,0)
// BEHAVIOUR
//  Reset (async, immediate): divCnt=0, hCount=vCount=0, hsync=vsync=1, rgb=0,
//   pxTick=0, inVblank=0, frameStart=0. Counting resumes on first clk after release.
//  Divider: divCnt counts 0..CLK_DIV-1; pxTick=1 when divCnt==CLK_DIV-1.
//   CLK_DIV==1: pxTick held 1 after reset.
//  Counters advance only on pxTick: hCount 0..H_TOTAL-1 wraps to 0 and increments
//   vCount; vCount 0..V_TOTAL-1 wraps to 0. Both widths 10 bits; no overflow.
//  visible = (hCount<H_VISIBLE)&&(vCount<V_VISIBLE).
//  readX/readY = hCount/vCount when visible, else 0 (never address out of frame).
//  Output stage, loaded on pxTick from current counters (1 pixel tick latency,
//   all outputs aligned):
//   rgb   <= visible ? (color ? FG_COLOR : BG_COLOR) : 12'h000
//   hsync <= ~(hCount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1])
//   vsync <= ~(vCount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1])
//   inVblank <= (vCount >= V_VISIBLE)
//  frameStart = pxTick && hCount==H_TOTAL-1 && vCount==V_TOTAL-1 (comb, 1 clk).
//  color sampled only on pxTick while visible; X/garbage in blanking is ignored.
//  Writer may update the store at any time; a write landing on the pixel being
//   read in the same clk is seen on the next frame (tearing tolerated).
//  Reset mid-line/mid-frame: outputs forced to reset values at once; frame restarts
//   at (0,0); first frameStart is one full frame (H_TOTAL*V_TOTAL ticks) later.
// CONFIGURATION
//  BORDER_OVERLAY_EN defined: pixels with x==0, x==H_VISIBLE-1, y==0 or
//   y==V_VISIBLE-1 output FG_COLOR regardless of color; all else unchanged.
//  Not defined: rgb depends only on color and visible; no overlay logic built.
// TESTING (CLK_DIV=2, default timing, clk period 10)
//  1. Hold reset_n=0 then drop again mid-line -> hsync=vsync=1, rgb=0, readX=readY=0
//     same timestep; after release, readX increments every 2 clk.
//  2. Line timing -> hsync low exactly 192 clk, period 1600 clk; falling edge 1 tick
//     after hCount==656.
//  3. Frame timing -> vsync low 3200 clk, period 840000 clk; exactly one frameStart
//     per frame; inVblank high 45 lines (72000 clk).
//  4. Model color=(readX==5&&readY==3) -> rgb=FFF only on output tick for pixel
//     (5,3), 000 on all other ticks of the frame.
//  5. Tie color=1 -> rgb=FFF for 640x480 ticks per frame, 000 in all blanking;
//     readX/readY read 0 throughout blanking.
//  6. BORDER_OVERLAY_EN, color=0 -> rgb=FFF only at x=0/639 or y=0/479 (2236 px per
//     frame); without macro rgb=000 for the whole frame.

Source files
------------

// File: rtl/vga_scan_reader_if.sv
// Scan-reader bus: pixel-store read port plus the DAC-side video and status outputs.
interface vga_scan_reader_if;
  logic [9:0] readX;
  logic [9:0] readY;
  logic       color;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync;
  logic       vsync;
  logic       pxTick;
  logic       inVblank;
  logic       frameStart;

  modport master (
    output readX, readY, vga_r, vga_g, vga_b, hsync, vsync, pxTick, inVblank, frameStart,
    input  color
  );
  modport slave (
    input  readX, readY, vga_r, vga_g, vga_b, hsync, vsync, pxTick, inVblank, frameStart,
    output color
  );
endinterface

// File: rtl/vga_scan_reader.sv
// VGA timing generator and raster scanner for the 1-bit frame buffer.
// Optional macro BORDER_OVERLAY_EN forces FG_COLOR on the outermost visible pixels.
module vga_scan_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_scan_reader_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0]  H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic px_tick;

  // With no division the tick is held high from the first clock after reset.
  if (CLK_DIV == 1) begin : g_nodiv
    logic run_q, run_d;
    always_comb run_d = 1'b1;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) run_q <= 1'b0;
      else          run_q <= run_d;
    assign px_tick = run_q;
  end else begin : g_div
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    always_comb div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) div_cnt_q <= '0;
      else          div_cnt_q <= div_cnt_d;
    assign px_tick = (div_cnt_q == DIV_LAST);
  end

  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (px_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  logic visible;
  assign visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  // The store is never addressed outside the frame, so blanking reads (0,0).
  assign vga.readX = visible ? h_cnt_q : '0;
  assign vga.readY = visible ? v_cnt_q : '0;

  logic [11:0] pix_rgb;
`ifdef BORDER_OVERLAY_EN
  localparam logic [9:0] H_VIS_M1 = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
  logic border;
  assign border  = (h_cnt_q == '0) || (h_cnt_q == H_VIS_M1) ||
                   (v_cnt_q == '0) || (v_cnt_q == V_VIS_M1);
  assign pix_rgb = (vga.color || border) ? FG_COLOR : BG_COLOR;
`else
  assign pix_rgb = vga.color ? FG_COLOR : BG_COLOR;
`endif

  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;

  // Output stage samples the current pixel on the tick: one tick of latency, all aligned.
  always_comb begin
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vblank_d = vblank_q;
    if (px_tick) begin
      rgb_d    = visible ? pix_rgb : 12'h000;
      hsync_d  = ~((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      vsync_d  = ~((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      vblank_d = (v_cnt_q >= V_VIS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
    end
  end

  assign vga.vga_r      = rgb_q[11:8];
  assign vga.vga_g      = rgb_q[7:4];
  assign vga.vga_b      = rgb_q[3:0];
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.inVblank   = vblank_q;
  assign vga.pxTick     = px_tick;
  assign vga.frameStart = px_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader on a shrunken 15x10 raster (8x6 visible), CLK_DIV=2.
module tb_vga_scan_reader;
  // H: 8 vis, 2 fp, 3 sync, 2 bp = 15; V: 6 vis, 1 fp, 2 sync, 1 bp = 10; frame = 300 clk
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   mode = 0;

  vga_scan_reader_if bus();

  vga_scan_reader #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vga(bus)
  );

  always #5 clk = ~clk;

  // Pixel-store model
  always_comb begin
    case (mode)
      0:       bus.color = (bus.readX == 10'd5) && (bus.readY == 10'd3);
      1:       bus.color = 1'b1;
      default: bus.color = 1'b0;
    endcase
  end

  logic [11:0] rgb;
  assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

`ifdef BORDER_OVERLAY_EN
  localparam int OV = 1;
`else
  localparam int OV = 0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hsync"}, 32'(bus.hsync), 1);
    check({tag, "_vsync"}, 32'(bus.vsync), 1);
    check({tag, "_rgb"}, 32'(rgb), 0);
    check({tag, "_readX"}, 32'(bus.readX), 0);
    check({tag, "_readY"}, 32'(bus.readY), 0);
    check({tag, "_pxTick"}, 32'(bus.pxTick), 0);
    check({tag, "_inVblank"}, 32'(bus.inVblank), 0);
    check({tag, "_frameStart"}, 32'(bus.frameStart), 0);
  endtask

  typedef struct {
    logic [9:0] x;
    logic       tick;
  } step_t;

  typedef struct {
    int mode;
    int hs_low, hs_falls, vs_low, vs_falls, vblank, fs, fff, nz, pos_chk;
  } frame_t;

  step_t  steps[6];
  frame_t frames[3];
  int n, hs_low, hs_falls, vs_low, vs_falls, vb, fs, fff, nz, badpos;
  int t_hs, t_vs, t_vb;
  logic prev_hs, prev_vs, prev_vb, hit;
  logic [11:0] prev_rgb;

  initial begin
    steps = '{'{10'd0, 1'b1}, '{10'd1, 1'b0}, '{10'd1, 1'b1},
              '{10'd2, 1'b0}, '{10'd2, 1'b1}, '{10'd3, 1'b0}};
    frames = '{
      '{0, 60, 10, 60, 1, 120, 1, (OV != 0) ? 50 : 2,  94, (OV == 0) ? 1 : 0},
      '{1, 60, 10, 60, 1, 120, 1, 96,                  94, 0},
      '{2, 60, 10, 60, 1, 120, 1, (OV != 0) ? 48 : 0,  94, 0}
    };

    // Power-on reset, checked in the same timestep
    #1 reset_n = 1'b0;
    #1 check_reset_state("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // readX advances every second clock once released
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("step%0d_readX", k + 1), 32'(bus.readX), 32'(steps[k].x));
      check($sformatf("step%0d_pxTick", k + 1), 32'(bus.pxTick), 32'(steps[k].tick));
    end

    // First frameStart lands on the last tick of the first frame
    n = 6;
    while (!bus.frameStart && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("first_frameStart_clk", 32'(n), 299);

    // Whole-frame statistics over any 300-clock window
    for (int f = 0; f < 3; f++) begin
      mode = frames[f].mode;
      repeat (8) @(negedge clk);
      hs_low = 0; hs_falls = 0; vs_low = 0; vs_falls = 0;
      vb = 0; fs = 0; fff = 0; nz = 0; badpos = 0;
      prev_hs = bus.hsync; prev_vs = bus.vsync; prev_rgb = rgb;
      hit = bus.pxTick && (bus.readX == 10'd5) && (bus.readY == 10'd3);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (!bus.hsync) hs_low++;
        if (prev_hs && !bus.hsync) hs_falls++;
        if (!bus.vsync) vs_low++;
        if (prev_vs && !bus.vsync) vs_falls++;
        if (bus.inVblank) vb++;
        if (bus.frameStart) fs++;
        if (rgb == 12'hFFF) fff++;
        if (bus.readX != 10'd0 || bus.readY != 10'd0) nz++;
        if (rgb == 12'hFFF && prev_rgb != 12'hFFF && !hit) badpos++;
        prev_hs = bus.hsync; prev_vs = bus.vsync; prev_rgb = rgb;
        if (bus.pxTick) hit = (bus.readX == 10'd5) && (bus.readY == 10'd3);
      end
      check($sformatf("m%0d_hsync_low_clk", mode), 32'(hs_low), 32'(frames[f].hs_low));
      check($sformatf("m%0d_hsync_falls", mode), 32'(hs_falls), 32'(frames[f].hs_falls));
      check($sformatf("m%0d_vsync_low_clk", mode), 32'(vs_low), 32'(frames[f].vs_low));
      check($sformatf("m%0d_vsync_falls", mode), 32'(vs_falls), 32'(frames[f].vs_falls));
      check($sformatf("m%0d_vblank_clk", mode), 32'(vb), 32'(frames[f].vblank));
      check($sformatf("m%0d_frameStarts", mode), 32'(fs), 32'(frames[f].fs));
      check($sformatf("m%0d_fg_clk", mode), 32'(fff), 32'(frames[f].fff));
      check($sformatf("m%0d_addr_nonzero_clk", mode), 32'(nz), 32'(frames[f].nz));
      if (frames[f].pos_chk != 0)
        check($sformatf("m%0d_fg_position", mode), 32'(badpos), 0);
    end

    // Edge placement relative to frameStart
    mode = 0;
    n = 0;
    while (!bus.frameStart && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frameStart_seen", 32'(bus.frameStart), 1);
    t_hs = -1; t_vs = -1; t_vb = -1; prev_vb = bus.inVblank;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (t_hs < 0 && !bus.hsync) t_hs = c;
      if (t_vs < 0 && !bus.vsync) t_vs = c;
      if (t_vb < 0 && !prev_vb && bus.inVblank) t_vb = c;
      prev_vb = bus.inVblank;
    end
    check("hsync_fall_after_fs", 32'(t_hs), 23);
    check("vsync_fall_after_fs", 32'(t_vs), 213);
    check("vblank_rise_after_fs", 32'(t_vb), 183);

    // Reset dropped mid-line while readX is live
    n = 0;
    while (!bus.frameStart && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (9) @(negedge clk);
    check("midline_readX_live", 32'(bus.readX != 10'd0), 1);
    #3 reset_n = 1'b0;
    #1 check_reset_state("midline");
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!bus.frameStart && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("restart_frameStart_clk", 32'(n), 299);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
